// File: rtl/seq_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving every datapath strobe and select for the 8-bit MCU.
// Outputs are decoded combinationally from state; memory reads stall on mem_ready, bounded by MAX_WAIT before a sticky bus error.
module seq_control_unit #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] from_memory,
    input  logic              mem_ready,
    input  logic [3:0]        ccr,
    output logic              ir_load,
    output logic              mar_load,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [REG_AW-1:0] rd_addr_a,
    output logic [REG_AW-1:0] rd_addr_b,
    output logic [REG_AW-1:0] wr_addr,
    output logic              wr_en,
    output logic [3:0]        alu_sel,
    output logic              ccr_load,
    output logic              alu_b_sel,
    output logic              write,
    output logic [1:0]        bus1_sel,
    output logic [1:0]        bus2_sel,
    output logic              halted,
    output logic              bus_err
);

    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_DEC,
        S_OA0, S_OA1, S_OA2,
        S_OB0, S_OB1, S_OB2,
        S_MEM, S_EX, S_HALT
    } state_t;

    localparam logic [DATA_W-1:0] OP_BRA = DATA_W'(8'h20);
    localparam logic [DATA_W-1:0] OP_BVS = DATA_W'(8'h28);
    localparam logic [DATA_W-1:0] OP_LDI = DATA_W'(8'h80);
    localparam logic [DATA_W-1:0] OP_LD  = DATA_W'(8'h81);
    localparam logic [DATA_W-1:0] OP_ST  = DATA_W'(8'h82);
    localparam logic [DATA_W-1:0] OP_ADD = DATA_W'(8'h90);
    localparam logic [DATA_W-1:0] OP_XOR = DATA_W'(8'h94);
    localparam logic [DATA_W-1:0] OP_INC = DATA_W'(8'hA0);
    localparam logic [DATA_W-1:0] OP_DEC = DATA_W'(8'hA1);
    localparam logic [DATA_W-1:0] OP_HLT = DATA_W'(8'hFF);
    localparam logic [7:0]        MAX_WAIT_C = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              halted_q, halted_d;
    logic              bus_err_q, bus_err_d;

    logic op_branch, op_alu2, op_unary, op_valid, br_taken, in_wait, timeout;

    assign op_branch = (ir >= OP_BRA) && (ir <= OP_BVS);
    assign op_alu2   = (ir >= OP_ADD) && (ir <= OP_XOR);
    assign op_unary  = (ir == OP_INC) || (ir == OP_DEC);
    assign op_valid  = op_branch || op_alu2 || op_unary ||
                       (ir == OP_LDI) || (ir == OP_LD) || (ir == OP_ST);

    // ccr = {N,Z,V,C}; odd/even pairs test clear/set of the same flag
    always_comb begin
        br_taken = 1'b0;
        case (ir[3:0])
            4'h0: br_taken = 1'b1;
            4'h1: br_taken = ~ccr[0];
            4'h2: br_taken =  ccr[0];
            4'h3: br_taken = ~ccr[2];
            4'h4: br_taken =  ccr[2];
            4'h5: br_taken = ~ccr[3];
            4'h6: br_taken =  ccr[3];
            4'h7: br_taken = ~ccr[1];
            4'h8: br_taken =  ccr[1];
            default: br_taken = 1'b0;
        endcase
    end

    assign in_wait = (state_q == S_F2) || (state_q == S_OA2) || (state_q == S_OB2) ||
                     ((state_q == S_MEM) && (ir == OP_LD));
    assign timeout = in_wait && !mem_ready && (wait_cnt_q == MAX_WAIT_C);

    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        bus_err_d = bus_err_q;
        ir_load   = 1'b0;
        mar_load  = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_addr   = '0;
        wr_en     = 1'b0;
        alu_sel   = 4'd0;
        ccr_load  = 1'b0;
        alu_b_sel = 1'b0;
        write     = 1'b0;
        bus1_sel  = 2'b00;
        bus2_sel  = 2'b00;

        case (state_q)
            S_F0, S_OA0, S_OB0: begin
                bus2_sel = 2'b01;
                mar_load = 1'b1;
                state_d  = (state_q == S_F0) ? S_F1 : (state_q == S_OA0) ? S_OA1 : S_OB1;
            end
            S_F1, S_OA1, S_OB1: begin
                pc_inc  = 1'b1;
                state_d = (state_q == S_F1) ? S_F2 : (state_q == S_OA1) ? S_OA2 : S_OB2;
            end
            S_F2: begin
                bus2_sel = 2'b10;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (ir == OP_HLT)
                    state_d = S_HALT;
                else if (op_valid)
                    state_d = S_OA0;
                else
                    state_d = S_F0;
            end
            S_OA2: begin
                bus2_sel  = 2'b10;
                alu_b_sel = op_branch;
                if (mem_ready) begin
                    op1_d = from_memory;
                    if (op_branch) begin
                        pc_load = br_taken;
                        state_d = S_F0;
                    end else if (op_unary) begin
                        state_d = S_EX;
                    end else begin
                        state_d = S_OB0;
                    end
                end
            end
            S_OB2: begin
                bus2_sel = 2'b10;
                wr_addr  = op1_q[REG_AW-1:0];
                if (mem_ready) begin
                    if (ir == OP_LDI) begin
                        wr_en   = 1'b1;
                        state_d = S_F0;
                    end else if ((ir == OP_LD) || (ir == OP_ST)) begin
                        mar_load = 1'b1;
                        state_d  = S_MEM;
                    end else if (op_alu2) begin
                        op2_d   = from_memory;
                        state_d = S_EX;
                    end else begin
                        state_d = S_F0;
                    end
                end
            end
            S_MEM: begin
                if (ir == OP_LD) begin
                    bus2_sel = 2'b10;
                    wr_addr  = op1_q[REG_AW-1:0];
                    if (mem_ready) begin
                        wr_en   = 1'b1;
                        state_d = S_F0;
                    end
                end else begin
                    rd_addr_a = op1_q[REG_AW-1:0];
                    bus1_sel  = 2'b01;
                    write     = 1'b1;
                    state_d   = S_F0;
                end
            end
            S_EX: begin
                bus1_sel  = 2'b01;
                ccr_load  = 1'b1;
                wr_en     = 1'b1;
                rd_addr_a = op1_q[REG_AW-1:0];
                wr_addr   = op1_q[REG_AW-1:0];
                if (op_alu2) begin
                    rd_addr_b = op2_q[REG_AW-1:0];
                    case (ir[2:0])
                        3'd0:    alu_sel = 4'd0;
                        3'd1:    alu_sel = 4'd1;
                        3'd2:    alu_sel = 4'd4;
                        3'd3:    alu_sel = 4'd5;
                        default: alu_sel = 4'd6;
                    endcase
                end else begin
                    alu_sel = (ir == OP_DEC) ? 4'd8 : 4'd7;
                end
                state_d = S_F0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_F0;
        endcase

        // a stalled read that exhausts its budget abandons the instruction
        if (timeout) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end
        wait_cnt_d = (in_wait && !mem_ready && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_F0;
            op1_q      <= '0;
            op2_q      <= '0;
            wait_cnt_q <= 8'd0;
            halted_q   <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign halted  = halted_q;
    assign bus_err = bus_err_q;

    generate
        if (DATA_W > REG_AW) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^{op1_q[DATA_W-1:REG_AW], op2_q[DATA_W-1:REG_AW]};
        end
    endgenerate

endmodule
